// File: rtl/reflet_mem_arbiter_pkg.sv
// Shared types and legal parameter ranges for the reflet RAM arbiter.
package reflet_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      arb_idle   = 2'd0,
      arb_access = 2'd1,
      arb_done   = 2'd2
   } arb_state_t;

   localparam int unsigned n_req_min       = 2;
   localparam int unsigned n_req_max       = 8;
   localparam int unsigned ram_latency_min = 1;
   localparam int unsigned ram_latency_max = 4;

endpackage

// File: rtl/reflet_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1.
module reflet_rr_pick #(
   parameter int unsigned n_req = 2,
   parameter int unsigned id_w  = (n_req > 1) ? $clog2(n_req) : 1
) (
   input  logic [n_req-1:0] req,
   input  logic [id_w-1:0]  last,
   output logic [n_req-1:0] grant,
   output logic [id_w-1:0]  grant_id,
   output logic             any
);

   logic            found;
   logic [id_w-1:0] idx;

   // Walk candidates last+1 .. last+n_req (mod n_req); first hit wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 1; k <= n_req; k++) begin
         idx = id_w'((32'(last) + k) % n_req);
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/reflet_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between n_req word-access masters.
module reflet_mem_arbiter
   import reflet_mem_arbiter_pkg::*;
#(
   parameter int unsigned wordsize    = 16,
   parameter int unsigned n_req       = 2,
   parameter int unsigned ram_latency = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [n_req-1:0]          req,
   input  logic [n_req-1:0]          we,
   input  logic [n_req*wordsize-1:0] addr,
   input  logic [n_req*wordsize-1:0] wdata,
   output logic [wordsize-1:0]       rdata,
   output logic [n_req-1:0]          ack,
   output logic [wordsize-1:0]       ram_addr,
   output logic [wordsize-1:0]       ram_data_out,
   input  logic [wordsize-1:0]       ram_data_in,
   output logic                      ram_write_en,
   output logic                      busy
);

   localparam int unsigned id_w  = $clog2(n_req);
   localparam int unsigned lat_w = $clog2(ram_latency + 1);

   if (n_req < n_req_min || n_req > n_req_max) begin : g_bad_n_req
      $error("reflet_mem_arbiter: n_req must be in 2..8");
   end
   if (ram_latency < ram_latency_min || ram_latency > ram_latency_max) begin : g_bad_latency
      $error("reflet_mem_arbiter: ram_latency must be in 1..4");
   end

   logic [wordsize-1:0] addr_a  [n_req];
   logic [wordsize-1:0] wdata_a [n_req];

   for (genvar i = 0; i < n_req; i++) begin : g_unpack
      assign addr_a[i]  = addr[i*wordsize +: wordsize];
      assign wdata_a[i] = wdata[i*wordsize +: wordsize];
   end

   logic [n_req-1:0] pick_grant;
   logic [id_w-1:0]  pick_id;
   logic             pick_any;

   arb_state_t          state, state_nxt;
   logic [lat_w-1:0]    lat_cnt, lat_nxt;
   logic [id_w-1:0]     last, last_nxt;
   logic [wordsize-1:0] rdata_nxt, ram_addr_nxt, ram_data_out_nxt;
   logic [n_req-1:0]    ack_nxt;
   logic                wen_nxt, busy_nxt;

   reflet_rr_pick #(
      .n_req (n_req),
      .id_w  (id_w)
   ) u_pick (
      .req      (req),
      .last     (last),
      .grant    (pick_grant),
      .grant_id (pick_id),
      .any      (pick_any)
   );

   // State, latched command and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= arb_idle;
         lat_cnt      <= '0;
         last         <= id_w'(n_req - 1);
         rdata        <= '0;
         ack          <= '0;
         ram_addr     <= '0;
         ram_data_out <= '0;
         ram_write_en <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         lat_cnt      <= lat_nxt;
         last         <= last_nxt;
         rdata        <= rdata_nxt;
         ack          <= ack_nxt;
         ram_addr     <= ram_addr_nxt;
         ram_data_out <= ram_data_out_nxt;
         ram_write_en <= wen_nxt;
         busy         <= busy_nxt;
      end
   end

   // Next state; the RAM port registers double as the latched command.
   always_comb begin
      state_nxt        = state;
      lat_nxt          = lat_cnt;
      last_nxt         = last;
      rdata_nxt        = rdata;
      ram_addr_nxt     = ram_addr;
      ram_data_out_nxt = ram_data_out;
      ack_nxt          = '0;
      wen_nxt          = 1'b0;
      case (state)
         arb_idle: begin
            if (pick_any) begin
               state_nxt        = arb_access;
               last_nxt         = pick_id;
               lat_nxt          = '0;
               ram_addr_nxt     = addr_a[pick_id];
               ram_data_out_nxt = wdata_a[pick_id];
               wen_nxt          = |(pick_grant & we);
            end
         end
         arb_access: begin
            lat_nxt = lat_w'(lat_cnt + 1'b1);
            if (lat_cnt == lat_w'(ram_latency - 1)) begin
               rdata_nxt     = ram_data_in;
               ack_nxt[last] = 1'b1;
               state_nxt     = arb_done;
            end
         end
         arb_done: state_nxt = arb_idle;
         default:  state_nxt = arb_idle;
      endcase
      busy_nxt = (state_nxt != arb_idle);
   end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Directed bench for reflet_mem_arbiter: three instances cover latency 1/2 and 2/4 masters.
module tb_reflet_mem_arbiter;

   logic clk;
   logic reset;

   logic [1:0]  a_req, a_we, a_ack;
   logic [31:0] a_addr, a_wdata;
   logic [15:0] a_rdata, a_ram_addr, a_ram_do, a_ram_di;
   logic        a_wen, a_busy;

   logic [1:0]  b_req, b_we, b_ack;
   logic [31:0] b_addr, b_wdata;
   logic [15:0] b_rdata, b_ram_addr, b_ram_do, b_ram_di;
   logic        b_wen, b_busy;

   logic [3:0]  c_req, c_we, c_ack;
   logic [63:0] c_addr, c_wdata;
   logic [15:0] c_rdata, c_ram_addr, c_ram_do, c_ram_di;
   logic        c_wen, c_busy;

   int checks;
   int failures;

   reflet_mem_arbiter #(.wordsize(16), .n_req(2), .ram_latency(1)) dut_a (
      .clk(clk), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
      .rdata(a_rdata), .ack(a_ack), .ram_addr(a_ram_addr), .ram_data_out(a_ram_do),
      .ram_data_in(a_ram_di), .ram_write_en(a_wen), .busy(a_busy));

   reflet_mem_arbiter #(.wordsize(16), .n_req(2), .ram_latency(2)) dut_b (
      .clk(clk), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
      .rdata(b_rdata), .ack(b_ack), .ram_addr(b_ram_addr), .ram_data_out(b_ram_do),
      .ram_data_in(b_ram_di), .ram_write_en(b_wen), .busy(b_busy));

   reflet_mem_arbiter #(.wordsize(16), .n_req(4), .ram_latency(1)) dut_c (
      .clk(clk), .reset(reset), .req(c_req), .we(c_we), .addr(c_addr), .wdata(c_wdata),
      .rdata(c_rdata), .ack(c_ack), .ram_addr(c_ram_addr), .ram_data_out(c_ram_do),
      .ram_data_in(c_ram_di), .ram_write_en(c_wen), .busy(c_busy));

   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      checks++; if (a_ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", a_ack); end
      checks++; if (a_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", a_wen); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if (a_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", a_rdata); end
      checks++; if (a_ram_addr !== 16'h0000) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0000", a_ram_addr); end
      checks++; if (a_ram_do !== 16'h0000) begin failures++; $display("FAIL reset_ram_do got=%h exp=0000", a_ram_do); end
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_b_busy got=%b exp=0", b_busy); end
      checks++; if (c_ack !== 4'b0000) begin failures++; $display("FAIL reset_c_ack got=%b exp=0000", c_ack); end
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_write();
      b_req = 2'b01; b_we = 2'b01; b_addr[15:0] = 16'h0020; b_wdata[15:0] = 16'h5555;
      @(negedge clk);
      checks++; if (b_wen !== 1'b1) begin failures++; $display("FAIL rst_mid_wen_pre got=%b exp=1", b_wen); end
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_pre got=%b exp=1", b_busy); end
      reset = 1'b0;
      #1;
      checks++; if (b_wen !== 1'b0) begin failures++; $display("FAIL rst_mid_wen_async got=%b exp=0", b_wen); end
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_async got=%b exp=0", b_busy); end
      b_req = 2'b11; b_we = 2'b00; b_addr[31:16] = 16'h0030; b_ram_di = 16'h1111;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (b_ack !== 2'b00) begin failures++; $display("FAIL rst_mid_no_ack got=%b exp=00", b_ack); end
      end
      reset = 1'b1;
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0", b_busy); end
      @(negedge clk);
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL rst_regrant_busy got=%b exp=1", b_busy); end
      checks++; if (b_ram_addr !== 16'h0020) begin failures++; $display("FAIL rst_regrant_addr got=%h exp=0020", b_ram_addr); end
      checks++; if (b_wen !== 1'b0) begin failures++; $display("FAIL rst_regrant_wen got=%b exp=0", b_wen); end
      @(negedge clk);
      checks++; if (b_ack !== 2'b00) begin failures++; $display("FAIL rst_lat2_early_ack got=%b exp=00", b_ack); end
      @(negedge clk);
      checks++; if (b_ack !== 2'b01) begin failures++; $display("FAIL rst_lat2_ack got=%b exp=01", b_ack); end
      checks++; if (b_rdata !== 16'h1111) begin failures++; $display("FAIL rst_lat2_rdata got=%h exp=1111", b_rdata); end
      b_req = 2'b00;
      @(negedge clk);
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_lat2_idle got=%b exp=0", b_busy); end
   endtask

   task automatic test_single_read();
      a_we = 2'b00; a_addr[31:16] = 16'h0042; a_ram_di = 16'hBEEF; a_req = 2'b10;
      @(negedge clk);
      checks++; if (a_ram_addr !== 16'h0042) begin failures++; $display("FAIL read_ram_addr got=%h exp=0042", a_ram_addr); end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", a_busy); end
      checks++; if (a_ack !== 2'b00) begin failures++; $display("FAIL read_early_ack got=%b exp=00", a_ack); end
      checks++; if (a_wen !== 1'b0) begin failures++; $display("FAIL read_wen got=%b exp=0", a_wen); end
      @(negedge clk);
      checks++; if (a_ack !== 2'b10) begin failures++; $display("FAIL read_ack got=%b exp=10", a_ack); end
      checks++; if (a_rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=beef", a_rdata); end
      a_req = 2'b00;
      @(negedge clk);
      checks++; if (a_ack !== 2'b00) begin failures++; $display("FAIL read_ack_len got=%b exp=00", a_ack); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL read_idle got=%b exp=0", a_busy); end
   endtask

   task automatic test_back_to_back();
      int n_ack;
      logic [1:0] exp;
      n_ack = 0;
      a_we = 2'b00; a_addr = {16'h0200, 16'h0100}; a_req = 2'b11;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k % 3 == 2) exp = (((k / 3) % 2) == 0) ? 2'b01 : 2'b10;
         else exp = 2'b00;
         if (a_ack != 2'b00) n_ack++;
         checks++; if (a_ack !== exp) begin failures++; $display("FAIL b2b_ack cycle=%0d got=%b exp=%b", k, a_ack, exp); end
      end
      a_req = 2'b00;
      checks++; if (n_ack != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", n_ack); end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_single_write();
      int pulses;
      pulses = 0;
      a_we = 2'b01; a_addr[15:0] = 16'h0010; a_wdata[15:0] = 16'h1234; a_req = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (a_wen === 1'b1) pulses++;
         if (k == 1) begin
            checks++; if (a_wen !== 1'b1) begin failures++; $display("FAIL write_wen got=%b exp=1", a_wen); end
            checks++; if (a_ram_addr !== 16'h0010) begin failures++; $display("FAIL write_addr got=%h exp=0010", a_ram_addr); end
            checks++; if (a_ram_do !== 16'h1234) begin failures++; $display("FAIL write_data got=%h exp=1234", a_ram_do); end
         end
         if (k == 2) begin
            checks++; if (a_ack !== 2'b01) begin failures++; $display("FAIL write_ack got=%b exp=01", a_ack); end
            a_req = 2'b00;
         end
      end
      a_we = 2'b00;
      checks++; if (pulses != 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", pulses); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL write_idle got=%b exp=0", a_busy); end
   endtask

   task automatic test_addr_change();
      a_we = 2'b00; a_addr[31:16] = 16'h0300; a_ram_di = 16'hCAFE; a_req = 2'b10;
      @(negedge clk);
      checks++; if (a_ram_addr !== 16'h0300) begin failures++; $display("FAIL chg_addr_grant got=%h exp=0300", a_ram_addr); end
      a_addr[31:16] = 16'h0777; a_req = 2'b00;
      @(negedge clk);
      checks++; if (a_ack !== 2'b10) begin failures++; $display("FAIL chg_ack got=%b exp=10", a_ack); end
      checks++; if (a_ram_addr !== 16'h0300) begin failures++; $display("FAIL chg_addr_latched got=%h exp=0300", a_ram_addr); end
      checks++; if (a_rdata !== 16'hCAFE) begin failures++; $display("FAIL chg_rdata got=%h exp=cafe", a_rdata); end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL chg_idle got=%b exp=0", a_busy); end
      checks++; if (a_ram_addr !== 16'h0300) begin failures++; $display("FAIL chg_addr_hold got=%h exp=0300", a_ram_addr); end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL chg_stay_idle got=%b exp=0", a_busy); end
   endtask

   task automatic test_four_masters();
      logic [3:0] req_tab [19];
      logic [3:0] ack_tab [19];
      req_tab = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
                  4'b1010, 4'b1000, 4'b1000, 4'b1100, 4'b0100, 4'b0100, 4'b0110,
                  4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      ack_tab = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                  4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                  4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
      c_we = 4'b0000;
      c_req = req_tab[0];
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         checks++; if (c_ack !== ack_tab[k]) begin failures++; $display("FAIL n4_ack cycle=%0d got=%b exp=%b", k, c_ack, ack_tab[k]); end
         c_req = req_tab[k];
      end
      @(negedge clk);
      checks++; if (c_busy !== 1'b0) begin failures++; $display("FAIL n4_idle got=%b exp=0", c_busy); end
   endtask

   initial begin
      checks = 0; failures = 0;
      clk = 1'b0; reset = 1'b0;
      a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_ram_di = '0;
      b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_ram_di = '0;
      c_req = '0; c_we = '0; c_wdata = '0; c_ram_di = 16'h7777;
      c_addr = {16'h0403, 16'h0302, 16'h0201, 16'h0100};
      test_reset();
      test_reset_mid_write();
      test_single_read();
      test_back_to_back();
      test_single_write();
      test_addr_change();
      test_four_masters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
